// File: rtl/lisnoc_router_input_buffer_pkg.sv
// Shared lisnoc definitions: flit type encodings, framing states and flit width helper.
package lisnoc_router_input_buffer_pkg;

  // Flit type field, carried in the MSBs of every flit.
  typedef enum logic [1:0] {
    FlitPayload = 2'b00,
    FlitHeader  = 2'b01,
    FlitLast    = 2'b10,
    FlitSingle  = 2'b11
  } flit_type_e;

  // Per-VC packet framing states.
  localparam logic [0:0] StateIdle     = 1'b0;
  localparam logic [0:0] StateInPacket = 1'b1;

  // Total flit width: payload plus type field.
  function automatic int unsigned flit_width(input int unsigned data_width,
                                             input int unsigned type_width);
    return data_width + type_width;
  endfunction

endpackage

// File: rtl/lisnoc_router_input_buffer_vc_fifo.sv
// Single virtual-channel first-word fall-through FIFO with occupancy count.
module lisnoc_vc_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [Width-1:0] rd_data_o,
  output logic             valid_o,
  output logic             ready_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_wr;
  logic             do_rd;

  // Handshake qualification; both flags forced low while in reset.
  always_comb begin
    ready_o   = !rst && (count_q < CntW'(Depth));
    valid_o   = !rst && (count_q != '0);
    do_wr     = wr_i && ready_o;
    do_rd     = rd_i && valid_o;
    rd_data_o = mem_q[rd_ptr_q];
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/lisnoc_router_input_buffer.sv
// Router input buffer: one FIFO per virtual channel, link multi-hot detection and
// per-VC packet framing checks with sticky error flags.
module lisnoc_router_input_buffer
  import lisnoc_router_input_buffer_pkg::*;
#(
  parameter int unsigned flit_data_width = 32,
  parameter int unsigned flit_type_width = 2,
  parameter int unsigned vchannels       = 1,
  parameter int unsigned fifo_depth      = 4,
  localparam int unsigned FlitWidth      = flit_width(flit_data_width, flit_type_width)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [vchannels-1:0]           link_valid_i,
  input  logic [FlitWidth-1:0]           link_flit_i,
  output logic [vchannels-1:0]           link_ready_o,
  output logic [vchannels-1:0]           out_valid_o,
  output logic [vchannels*FlitWidth-1:0] out_flit_o,
  input  logic [vchannels-1:0]           out_ready_i,
  output logic [vchannels-1:0]           err_o
);

  logic                 multi_hot;
  logic [vchannels-1:0] wr_en;
  logic [vchannels-1:0] state_q;
  logic [vchannels-1:0] state_d;
  logic [vchannels-1:0] err_q;
  logic [vchannels-1:0] err_d;
  flit_type_e           ftype;

  // Link decode: a multi-hot valid vector blocks every write that cycle.
  always_comb begin
    multi_hot = (link_valid_i & (link_valid_i - vchannels'(1))) != '0;
    ftype     = flit_type_e'(link_flit_i[FlitWidth-1 -: 2]);
    wr_en     = link_valid_i & link_ready_o & {vchannels{!multi_hot}};
  end

  // Framing FSM next state and error accumulation, per VC, on accepted writes.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    for (int unsigned v = 0; v < vchannels; v++) begin
      if (multi_hot && link_valid_i[v]) err_d[v] = 1'b1;
      if (wr_en[v]) begin
        if (state_q[v] == StateIdle) begin
          unique case (ftype)
            FlitHeader:  state_d[v] = StateInPacket;
            FlitSingle:  state_d[v] = StateIdle;
            FlitPayload: begin
              state_d[v] = StateInPacket;
              err_d[v]   = 1'b1;
            end
            FlitLast: begin
              state_d[v] = StateIdle;
              err_d[v]   = 1'b1;
            end
          endcase
        end else begin
          unique case (ftype)
            FlitPayload: state_d[v] = StateInPacket;
            FlitLast:    state_d[v] = StateIdle;
            FlitHeader: begin
              state_d[v] = StateInPacket;
              err_d[v]   = 1'b1;
            end
            FlitSingle: begin
              state_d[v] = StateIdle;
              err_d[v]   = 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Framing state and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= {vchannels{StateIdle}};
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    lisnoc_vc_fifo #(
      .Width (FlitWidth),
      .Depth (fifo_depth)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr_en[v]),
      .wr_data_i (link_flit_i),
      .rd_i      (out_ready_i[v]),
      .rd_data_o (out_flit_o[v*FlitWidth +: FlitWidth]),
      .valid_o   (out_valid_o[v]),
      .ready_o   (link_ready_o[v])
    );
  end

endmodule

// File: tb/tb_lisnoc_router_input_buffer.sv
// Scoreboard bench for the router input buffer: stimulus process predicts accepted
// flits into per-VC queues; a negedge monitor compares the DUT outputs against them.
module tb_lisnoc_router_input_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 2;
  localparam int unsigned VC    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = DW + TW;

  localparam logic [1:0] T_PAY  = 2'b00;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_LAST = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [VC-1:0]    link_valid_i = '0;
  logic [FW-1:0]    link_flit_i = '0;
  logic [VC-1:0]    link_ready_o;
  logic [VC-1:0]    out_valid_o;
  logic [VC*FW-1:0] out_flit_o;
  logic [VC-1:0]    out_ready_i = '0;
  logic [VC-1:0]    err_o;

  always #5 clk = ~clk;

  lisnoc_router_input_buffer #(
    .flit_data_width (DW),
    .flit_type_width (TW),
    .vchannels       (VC),
    .fifo_depth      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link_valid_i (link_valid_i),
    .link_flit_i  (link_flit_i),
    .link_ready_o (link_ready_o),
    .out_valid_o  (out_valid_o),
    .out_flit_o   (out_flit_o),
    .out_ready_i  (out_ready_i),
    .err_o        (err_o)
  );

  // Reference model: occupancy, expected contents, packet state, sticky errors.
  int            cnt [VC];
  logic [FW-1:0] exp_q [VC][$];
  bit            in_pkt [VC];
  logic [VC-1:0] merr = '0;
  int            wr_p [VC];
  int            rd_p [VC];
  logic [VC-1:0] err_p = '0;
  bit            rst_p = 1'b1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  // One clock of stimulus; model effects become visible after the following edge.
  task automatic cycle(input bit r, input logic [VC-1:0] vld, input logic [FW-1:0] flit,
                       input logic [VC-1:0] rdy);
    bit         multi;
    bit         starts;
    bit         ends;
    logic [1:0] t;
    @(posedge clk);
    #1;
    for (int v = 0; v < VC; v++) begin
      if (rst_p) begin
        cnt[v] = 0;
        exp_q[v].delete();
        in_pkt[v] = 1'b0;
      end else begin
        cnt[v] += wr_p[v] - rd_p[v];
      end
      wr_p[v] = 0;
      rd_p[v] = 0;
    end
    if (rst_p) merr = '0;
    else merr |= err_p;
    err_p = '0;
    rst_p = r;
    rst          = r;
    link_valid_i = vld;
    link_flit_i  = flit;
    out_ready_i  = rdy;
    if (!r) begin
      multi = $countones(vld) > 1;
      t = flit[FW-1 -: 2];
      starts = (t == T_HDR) || (t == T_SGL);
      ends   = (t == T_LAST) || (t == T_SGL);
      for (int v = 0; v < VC; v++) begin
        if (multi && vld[v]) begin
          err_p[v] = 1'b1;
        end else if (vld[v] && !multi && cnt[v] < DEPTH) begin
          exp_q[v].push_back(flit);
          wr_p[v] = 1;
          // A packet start is legal only when idle; anything else only mid-packet.
          if (starts == in_pkt[v]) err_p[v] = 1'b1;
          in_pkt[v] = !ends;
        end
        if (rdy[v] && cnt[v] > 0) rd_p[v] = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0, '0);
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, '0, '0, '1);
  endtask

  // Monitor: compares DUT outputs mid-cycle and retires flits on handshakes.
  initial begin
    bit ev;
    bit er;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int v = 0; v < VC; v++) begin
        ev = !rst && cnt[v] != 0;
        er = !rst && cnt[v] < DEPTH;
        chk($sformatf("out_valid[%0d]", v), 64'(out_valid_o[v]), 64'(ev));
        chk($sformatf("link_ready[%0d]", v), 64'(link_ready_o[v]), 64'(er));
        if (ev) begin
          if (exp_q[v].size() == 0) begin
            chk($sformatf("scoreboard_empty[%0d]", v), 64'(1), 64'(0));
          end else begin
            chk($sformatf("out_flit[%0d]", v), 64'(out_flit_o[v*FW +: FW]),
                64'(exp_q[v][0]));
            if (out_ready_i[v]) void'(exp_q[v].pop_front());
          end
        end
      end
      chk("err", 64'(err_o), 64'(merr));
    end
  end

  initial begin
    logic [VC-1:0] vld;
    int            sel;
    logic [1:0]    rt;
    cycle(1'b1, '0, '0, '0);
    cycle(1'b1, '0, '0, '0);

    // Three-flit packet on VC0, nothing consumed.
    cycle(1'b0, 2'b01, mk(T_HDR, 32'h1111_0000), 2'b00);
    cycle(1'b0, 2'b01, mk(T_PAY, 32'h1111_0001), 2'b00);
    cycle(1'b0, 2'b01, mk(T_LAST, 32'h1111_0002), 2'b00);
    idle(2);
    drain(4);

    // Fill VC1, one extra flit refused, then a single read reopens it.
    for (int k = 0; k < 4; k++) cycle(1'b0, 2'b10, mk(T_SGL, 32'h2222_0000 + k), 2'b00);
    cycle(1'b0, 2'b10, mk(T_SGL, 32'h0000_0BAD), 2'b00);
    cycle(1'b0, 2'b00, '0, 2'b10);
    idle(2);
    drain(5);

    // Steady state at count 2 with concurrent write and read across pointer wrap.
    cycle(1'b0, 2'b01, mk(T_HDR, 32'h3333_0000), 2'b00);
    cycle(1'b0, 2'b01, mk(T_PAY, 32'h3333_0001), 2'b00);
    for (int k = 0; k < 6; k++) cycle(1'b0, 2'b01, mk(T_PAY, 32'h3333_0002 + k), 2'b01);
    cycle(1'b0, 2'b01, mk(T_LAST, 32'h3333_00FF), 2'b01);
    drain(5);

    // Payload while idle: stored, error on VC0 only.
    cycle(1'b1, '0, '0, '0);
    cycle(1'b0, 2'b01, mk(T_PAY, 32'hDEAD_BEEF), 2'b00);
    idle(3);
    drain(3);

    // Multi-hot link valid: no writes, both errors.
    cycle(1'b1, '0, '0, '0);
    cycle(1'b0, 2'b11, mk(T_SGL, 32'h4444_0000), 2'b00);
    idle(2);

    // Reset mid-packet, then a clean single-flit packet.
    cycle(1'b1, '0, '0, '0);
    cycle(1'b0, 2'b01, mk(T_HDR, 32'h5555_0000), 2'b00);
    cycle(1'b0, 2'b01, mk(T_PAY, 32'h5555_0001), 2'b00);
    cycle(1'b0, 2'b01, mk(T_PAY, 32'h5555_0002), 2'b00);
    cycle(1'b1, 2'b01, mk(T_PAY, 32'h5555_0003), 2'b01);
    cycle(1'b0, 2'b01, mk(T_SGL, 32'h5555_0004), 2'b00);
    idle(2);
    drain(3);

    // Randomised traffic with periodic resets so error flags keep meaning something.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        cycle(1'b1, 2'($urandom_range(0, 3)), FW'({$urandom(), $urandom()}),
              2'($urandom_range(0, 3)));
      end else begin
        sel = $urandom_range(0, 19);
        if (sel < 8) vld = 2'b01;
        else if (sel < 16) vld = 2'b10;
        else if (sel < 19) vld = 2'b00;
        else vld = 2'b11;
        rt = 2'($urandom_range(0, 3));
        cycle(1'b0, vld, mk(rt, $urandom()), 2'($urandom_range(0, 3)));
      end
    end
    drain(6);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
